// File: rtl/amiq_fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e  : arbiter FSM states (idle, granted, throttled on almost-full)
//   DefaultBurst : default maximum beats per grant
//   CountW       : width of the per-grant beat counter
//   wrap_inc     : modulo increment used for the round-robin pointer
package amiq_fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StGrant    = 2'd1,
    StThrottle = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultBurst = 4;
  localparam int unsigned CountW       = 8;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
    return (idx + 1 == modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/amiq_fifo_wr_arb_if.sv
// Requester / FIFO side bundle of the FIFO write arbiter.
//   req, req_data          : per-requester write requests and packed data (slice i at [i*N +: N])
//   gnt, cur_owner, busy   : registered grant state
//   fifo_wr_en/_data       : write port towards the FIFO
//   fifo_full/_alm_full    : FIFO status flags
// master: requesters + FIFO model side; slave: the arbiter.
interface amiq_fifo_wr_arb_if #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
);
  localparam int unsigned IdxW = $clog2(K);

  logic [K-1:0]    req;
  logic [K*N-1:0]  req_data;
  logic [K-1:0]    gnt;
  logic            fifo_wr_en;
  logic [N-1:0]    fifo_wr_data;
  logic            fifo_full;
  logic            fifo_alm_full;
  logic [IdxW-1:0] cur_owner;
  logic            busy;

  modport master (
    output req, req_data, fifo_full, fifo_alm_full,
    input  gnt, fifo_wr_en, fifo_wr_data, cur_owner, busy
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_alm_full,
    output gnt, fifo_wr_en, fifo_wr_data, cur_owner, busy
  );
endinterface

// File: rtl/amiq_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i    : request vector
//   rr_ptr_i : index with highest priority this cycle
//   idx_o    : first requesting index at or after rr_ptr_i (circular)
//   valid_o  : any request present
module amiq_rr_pick #(
  parameter int unsigned K    = 4,
  parameter int unsigned IdxW = $clog2(K)
) (
  input  logic [K-1:0]    req_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < K; i++) begin
      cand     = (32'(rr_ptr_i) + i) % K;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/amiq_fifo_wr_arb.sv
// Round-robin write arbiter: K requesters share one FIFO write port, each grant lasting at most
// BURST beats. An owner keeps the port until its burst completes or it drops its request; after
// release the arbiter passes through IDLE (or THROTTLE while the FIFO is almost full).
//   clk, rst_n : clock, asynchronous active-low reset
//   arb_if     : requests/data in, grant state out, FIFO write port and status flags
module amiq_fifo_wr_arb
  import amiq_fifo_arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned BURST = DefaultBurst
) (
  input  logic                clk,
  input  logic                rst_n,
  amiq_fifo_wr_arb_if.slave   arb_if
);

  localparam int unsigned IdxW = $clog2(K);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [K-1:0]    gnt_q, gnt_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            owner_req;
  logic            xfer;
  logic            rel;

  amiq_rr_pick #(
    .K    (K),
    .IdxW (IdxW)
  ) u_pick (
    .req_i    (arb_if.req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign owner_req = arb_if.req[owner_q];
  assign xfer      = (state_q == StGrant) && owner_req && !arb_if.fifo_full;
  // The final beat is still written in the cycle that releases the grant.
  assign rel       = (state_q == StGrant) &&
                     (!owner_req || (xfer && (count_q == CountW'(BURST - 1))));

  assign arb_if.fifo_wr_en   = xfer;
  assign arb_if.fifo_wr_data = (state_q == StGrant) ? arb_if.req_data[int'(owner_q) * N +: N]
                                                    : '0;
  assign arb_if.gnt          = gnt_q;
  assign arb_if.cur_owner    = owner_q;
  assign arb_if.busy         = (state_q == StGrant);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !arb_if.fifo_full) begin
          state_d         = StGrant;
          owner_d         = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          count_d         = '0;
        end
      end
      StGrant: begin
        if (rel) begin
          state_d  = arb_if.fifo_alm_full ? StThrottle : StIdle;
          rr_ptr_d = IdxW'(wrap_inc(32'(owner_q), K));
          owner_d  = '0;
          gnt_d    = '0;
        end else if (xfer) begin
          count_d = count_q + 1'b1;
        end
      end
      StThrottle: begin
        if (!arb_if.fifo_alm_full) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      gnt_q    <= gnt_d;
    end
  end

endmodule

// File: tb/tb_amiq_fifo_wr_arb.sv
// Directed bench for amiq_fifo_wr_arb (N=8, K=4, BURST=4). Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later. A monitor records every FIFO write and the
// sequence is compared with the beats expected in grant order.
module tb_amiq_fifo_wr_arb;

  localparam int unsigned N     = 8;
  localparam int unsigned K     = 4;
  localparam int unsigned BURST = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];

  amiq_fifo_wr_arb_if #(.N(N), .K(K)) arb_if ();

  amiq_fifo_wr_arb #(
    .N     (N),
    .K     (K),
    .BURST (BURST)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && arb_if.fifo_wr_en) got_q.push_back(arb_if.fifo_wr_data);
  end

  // Requester i drives the constant byte 0x11*(i+1).
  function automatic logic [N-1:0] slice_of(input int i);
    logic [31:0] v;
    v = 32'h11 * (i + 1);
    return v[N-1:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [K-1:0] r, input logic full, input logic alm);
    arb_if.req           = r;
    arb_if.fifo_full     = full;
    arb_if.fifo_alm_full = alm;
    #1;
  endtask

  task automatic expect_grant(input string tag, input int o, input logic wr);
    check_eq({tag, ".gnt"},   32'(arb_if.gnt), 32'(1) << o);
    check_eq({tag, ".owner"}, 32'(arb_if.cur_owner), o);
    check_eq({tag, ".busy"},  32'(arb_if.busy), 32'd1);
    check_eq({tag, ".wr_en"}, 32'(arb_if.fifo_wr_en), 32'(wr));
    if (wr) begin
      check_eq({tag, ".data"}, 32'(arb_if.fifo_wr_data), 32'(slice_of(o)));
      exp_q.push_back(slice_of(o));
    end
  endtask

  task automatic expect_free(input string tag);
    check_eq({tag, ".gnt"},   32'(arb_if.gnt), 32'd0);
    check_eq({tag, ".owner"}, 32'(arb_if.cur_owner), 32'd0);
    check_eq({tag, ".busy"},  32'(arb_if.busy), 32'd0);
    check_eq({tag, ".wr_en"}, 32'(arb_if.fifo_wr_en), 32'd0);
    check_eq({tag, ".data"},  32'(arb_if.fifo_wr_data), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests              = 0;
    n_fail               = 0;
    rst_n                = 1'b0;
    arb_if.req           = '0;
    arb_if.req_data      = 32'h44332211;
    arb_if.fifo_full     = 1'b0;
    arb_if.fifo_alm_full = 1'b0;

    // Reset holds everything off even with all requests high.
    repeat (2) next_cycle();
    drive(4'b1111, 1'b0, 1'b0);
    expect_free("rst");
    rst_n = 1'b1;
    #1;
    expect_free("idle0");

    // A: all requesting -> 0,1,2,3,0, four beats each, one idle cycle between grants.
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        next_cycle();
        drive(4'b1111, 1'b0, 1'b0);
        expect_grant("A", g % 4, 1'b1);
      end
      next_cycle();
      drive((g == 4) ? 4'b0000 : 4'b1111, 1'b0, 1'b0);
      expect_free("A.gap");
    end

    // B: requester 2 alone for two beats then drops; rr_ptr must land on 3.
    next_cycle();
    drive(4'b0100, 1'b0, 1'b0);
    expect_free("B.idle");
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      drive(4'b0100, 1'b0, 1'b0);
      expect_grant("B", 2, 1'b1);
    end
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_grant("B.drop", 2, 1'b0);
    next_cycle();
    drive(4'b1011, 1'b0, 1'b0);
    expect_free("B.rel");
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_grant("B.ptr", 3, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_free("B.end");

    // C: owner 1 stalled by fifo_full for five cycles after beat 2, then finishes four beats.
    next_cycle();
    drive(4'b0010, 1'b0, 1'b0);
    expect_free("C.idle");
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      drive(4'b0010, 1'b0, 1'b0);
      expect_grant("C.pre", 1, 1'b1);
    end
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      drive(4'b0010, 1'b1, 1'b0);
      expect_grant("C.full", 1, 1'b0);
    end
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      drive(4'b0010, 1'b0, 1'b0);
      expect_grant("C.post", 1, 1'b1);
    end
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_free("C.rel");

    // D: almost-full at release -> THROTTLE until it drops, then one IDLE cycle, then grant.
    next_cycle();
    drive(4'b0100, 1'b0, 1'b0);
    expect_free("D.idle");
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      drive(4'b0100, 1'b0, 1'b0);
      expect_grant("D", 2, 1'b1);
    end
    next_cycle();
    drive(4'b0100, 1'b0, 1'b1);
    expect_grant("D.last", 2, 1'b1);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      drive(4'b0100, 1'b0, 1'b1);
      expect_free("D.thr");
    end
    next_cycle();
    drive(4'b0100, 1'b0, 1'b0);
    expect_free("D.thr_exit");
    next_cycle();
    drive(4'b0100, 1'b0, 1'b0);
    expect_free("D.idle2");
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_grant("D.regrant", 2, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_free("D.end");

    // E: IDLE with fifo_full stays idle; grant follows once full clears (wraps 3 -> 0).
    for (int s = 0; s < 2; s++) begin
      next_cycle();
      drive(4'b0001, 1'b1, 1'b0);
      expect_free("E.full");
    end
    next_cycle();
    drive(4'b0001, 1'b0, 1'b0);
    expect_free("E.unfull");
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_grant("E.grant", 0, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_free("E.end");

    // F: reset after beat 2 of owner 3 aborts immediately; requester 3 is regranted afterwards.
    next_cycle();
    drive(4'b1000, 1'b0, 1'b0);
    expect_free("F.idle");
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      drive(4'b1000, 1'b0, 1'b0);
      expect_grant("F", 3, 1'b1);
    end
    next_cycle();
    drive(4'b1000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_free("F.rst");
    next_cycle();
    drive(4'b1000, 1'b0, 1'b0);
    expect_free("F.rst2");
    rst_n = 1'b1;
    #1;
    expect_free("F.post");
    next_cycle();
    drive(4'b1000, 1'b0, 1'b0);
    expect_grant("F.regrant", 3, 1'b1);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_grant("F.drop", 3, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0);
    expect_free("F.end");

    // Scoreboard: every observed write, in order, against the expected beats.
    next_cycle();
    check_eq("sb.len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("sb.data[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
